// File: rtl/sys_defs.sv
// Shared system definitions: data widths, the fetch/dispatch packet type,
// the canonical NOP encoding and the default instruction-buffer depth.
package sys_defs;

  localparam int XLEN     = 32;
  localparam int IB_DEPTH = 8;

  // RV32I "addi x0, x0, 0"
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] PC;
  } IF_IB_PACKET;

endpackage

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and dispatch: a circular FIFO of fetch
// packets. Full/empty come only from registered state so fetch never sees a
// combinational path through dispatch. Squash flushes everything.
module instr_buffer
  import sys_defs::IF_IB_PACKET;
  import sys_defs::NOP;
#(
  parameter int IB_DEPTH = sys_defs::IB_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  IF_IB_PACKET                   if_ib_packet,
  input  logic                          dp_take,
  output IF_IB_PACKET                   ib_dp_packet,
  output logic                          ib_full,
  output logic                          ib_empty,
  output logic [$clog2(IB_DEPTH+1)-1:0] ib_count
);

  localparam int PTR_W = $clog2(IB_DEPTH);
  localparam int CNT_W = $clog2(IB_DEPTH+1);

  IF_IB_PACKET            mem [IB_DEPTH];
  logic [PTR_W-1:0]       head, tail;
  logic [CNT_W-1:0]       count;
  logic                   push, pop;

  assign ib_full  = (count == CNT_W'(IB_DEPTH));
  assign ib_empty = (count == '0);
  assign ib_count = count;

  // Full is sampled from registered count, so a same-cycle pop cannot make
  // room for a same-cycle push.
  assign push = if_ib_packet.valid & ~ib_full  & ~squash;
  assign pop  = dp_take            & ~ib_empty & ~squash;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= if_ib_packet;
  end

  // Head entry to dispatch; masked to an invalid NOP when nothing is held.
  always_comb begin
    ib_dp_packet = mem[head];
    if (ib_empty) begin
      ib_dp_packet.valid = 1'b0;
      ib_dp_packet.inst  = NOP;
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: fill/drain, full-with-pop, streaming
// push+pop across pointer wrap, squash and mid-operation reset.
module tb_instr_buffer;
  import sys_defs::*;

  logic        clock;
  logic        reset;
  logic        squash;
  IF_IB_PACKET if_ib_packet;
  logic        dp_take;
  IF_IB_PACKET ib_dp_packet;
  logic        ib_full;
  logic        ib_empty;
  logic [3:0]  ib_count;

  int total = 0;
  int bad   = 0;

  instr_buffer #(.IB_DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .if_ib_packet(if_ib_packet),
    .dp_take     (dp_take),
    .ib_dp_packet(ib_dp_packet),
    .ib_full     (ib_full),
    .ib_empty    (ib_empty),
    .ib_count    (ib_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive fetch; inst/NPC derived from PC so every field is checkable.
  task automatic drive(input logic vld, input logic [31:0] pc, input logic take, input logic sq);
    if_ib_packet.valid = vld;
    if_ib_packet.PC    = pc;
    if_ib_packet.NPC   = pc + 32'd4;
    if_ib_packet.inst  = 32'hA000_0000 | pc;
    dp_take            = take;
    squash             = sq;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); step(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ib_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", ib_empty); end
    total++; if (ib_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", ib_full); end
    total++; if (ib_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ib_count); end
    total++; if (ib_dp_packet.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ib_dp_packet.valid); end
    total++; if (ib_dp_packet.inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h exp=%h", ib_dp_packet.inst, NOP); end
    // pop while empty is ignored
    drive(1'b0, 32'h0, 1'b1, 1'b0); step(); idle();
    total++; if (ib_count !== 4'd0 || ib_empty !== 1'b1) begin bad++; $display("FAIL pop_empty got=%0d exp=0", ib_count); end
  endtask

  // Eight pushes PC 0x0..0x1C, then a ninth that must be dropped.
  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4*i), 1'b0, 1'b0); step();
      if (i == 0) begin
        total++; if (ib_dp_packet.valid !== 1'b1 || ib_dp_packet.PC !== 32'h0) begin
          bad++; $display("FAIL latency got=%b/%h exp=1/00000000", ib_dp_packet.valid, ib_dp_packet.PC); end
      end
    end
    idle();
    total++; if (ib_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", ib_full); end
    total++; if (ib_count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", ib_count); end
    drive(1'b1, 32'h20, 1'b0, 1'b0); step(); idle();
    total++; if (ib_count !== 4'd8) begin bad++; $display("FAIL overflow_count got=%0d exp=8", ib_count); end
    total++; if (ib_dp_packet.PC !== 32'h0) begin bad++; $display("FAIL overflow_head got=%h exp=00000000", ib_dp_packet.PC); end
  endtask

  // Drain n entries expecting consecutive PCs from first_pc.
  task automatic drain(input int n, input logic [31:0] first_pc, input string tag);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = first_pc + 32'(4*i);
      total++; if (ib_dp_packet.valid !== 1'b1 || ib_dp_packet.PC !== pc ||
                   ib_dp_packet.NPC !== pc + 32'd4 || ib_dp_packet.inst !== (32'hA000_0000 | pc)) begin
        bad++; $display("FAIL %s_pc%0d got=%b/%h/%h/%h exp=1/%h", tag, i, ib_dp_packet.valid,
                        ib_dp_packet.PC, ib_dp_packet.NPC, ib_dp_packet.inst, pc); end
      drive(1'b0, 32'h0, 1'b1, 1'b0); step();
    end
    idle();
    total++; if (ib_empty !== 1'b1 || ib_dp_packet.valid !== 1'b0) begin
      bad++; $display("FAIL %s_empty got=%b/%b exp=1/0", tag, ib_empty, ib_dp_packet.valid); end
  endtask

  task automatic test_drain();
    drain(8, 32'h0, "drain8");
  endtask

  // Full buffer: push+pop same cycle pops head and drops the push.
  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin drive(1'b1, 32'(4*i), 1'b0, 1'b0); step(); end
    drive(1'b1, 32'h20, 1'b1, 1'b0); step(); idle();
    total++; if (ib_count !== 4'd7) begin bad++; $display("FAIL fullpp_count got=%0d exp=7", ib_count); end
    total++; if (ib_full !== 1'b0) begin bad++; $display("FAIL fullpp_full got=%b exp=0", ib_full); end
    drain(7, 32'h4, "fullpp");
  endtask

  // Count=3 streaming push+pop for 20 cycles across pointer wrap.
  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0); step(); end
    exp_pc = 32'h100;
    for (int k = 0; k < 20; k++) begin
      total++; if (ib_dp_packet.PC !== exp_pc || ib_dp_packet.valid !== 1'b1) begin
        bad++; $display("FAIL b2b_head%0d got=%h exp=%h", k, ib_dp_packet.PC, exp_pc); end
      drive(1'b1, 32'h10C + 32'(4*k), 1'b1, 1'b0); step();
      exp_pc = exp_pc + 32'd4;
      total++; if (ib_count !== 4'd3) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=3", k, ib_count); end
    end
    idle();
    drain(3, 32'h150, "b2b_tail");
  endtask

  // Squash beats push and pop; squashed PC never shows up.
  task automatic test_squash();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 32'h200 + 32'(4*i), 1'b0, 1'b0); step(); end
    total++; if (ib_count !== 4'd5) begin bad++; $display("FAIL sq_pre got=%0d exp=5", ib_count); end
    drive(1'b1, 32'hDEAD0, 1'b1, 1'b1); step(); idle();
    total++; if (ib_count !== 4'd0 || ib_empty !== 1'b1) begin bad++; $display("FAIL sq_count got=%0d exp=0", ib_count); end
    total++; if (ib_dp_packet.valid !== 1'b0) begin bad++; $display("FAIL sq_valid got=%b exp=0", ib_dp_packet.valid); end
    drive(1'b1, 32'h500, 1'b0, 1'b0); step(); idle();
    total++; if (ib_dp_packet.PC !== 32'h500 || ib_count !== 4'd1) begin
      bad++; $display("FAIL sq_after got=%h/%0d exp=00000500/1", ib_dp_packet.PC, ib_count); end
  endtask

  // Reset with count=4 and a pending push clears everything.
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 32'h300 + 32'(4*i), 1'b0, 1'b0); step(); end
    reset = 1'b1; drive(1'b1, 32'h400, 1'b1, 1'b0); step(); reset = 1'b0; idle();
    total++; if (ib_count !== 4'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", ib_count); end
    total++; if (ib_dp_packet.valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", ib_dp_packet.valid); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_full_push_pop();
    test_back_to_back();
    test_squash();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
